// File: rtl/cpu_tick_controller.sv
// Clock-enable generator for the tiny processor: free-run, pause, and debounced single-step ticks.
// Also counts issued ticks and toggles a heartbeat on each one.
`timescale 1ns/1ps

module cpu_tick_controller #(
  parameter int DIV_LOG2  = 25,
  parameter int RATE_STEP = 3,
  parameter int DEB_LOG2  = 20,
  parameter int CNT_W     = 16
) (
  input  logic             sysclk,
  input  logic             reset_p,
  input  logic [1:0]       mode,
  input  logic [1:0]       rate_sel,
  input  logic             step_btn,
  output logic             tick,
  output logic             heartbeat,
  output logic             running,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_LOG2-1:0]   div_q, div_d;
  logic [DIV_LOG2-1:0]   div_mask;
  logic                  sync1_q, sync2_q;
  logic                  deb_q, deb_d;
  logic                  deb_prev_q;
  logic [DEB_LOG2-1:0]   deb_cnt_q, deb_cnt_d;
  logic                  step_edge_q, step_edge_d;
  logic                  tick_q, tick_d;
  logic                  hb_q, hb_d;
  logic                  running_q, running_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_hit;

  // Reserved mode 11 falls into the default arm and pauses the core.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = S_PAUSE;
    case (mode)
      2'b01:   state_d = S_RUN;
      2'b10:   state_d = S_STEP;
      default: state_d = S_PAUSE;
    endcase
  end

  // Tick when the low k bits of the divider are all ones, k = DIV_LOG2 - RATE_STEP*rate_sel.
  always_comb begin
    div_mask = {DIV_LOG2{1'b1}} >> (RATE_STEP * int'(rate_sel));
    run_hit  = (state_q == S_RUN) && ((div_q & div_mask) == div_mask);
    div_d    = '0;
    if (state_d == state_q && state_q == S_RUN) begin
      div_d = div_q + DIV_LOG2'(1);
    end
  end

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == '1) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_LOG2'(1);
    end
  end

  // Rising edges seen outside S_STEP are dropped here rather than queued.
  always_comb begin
    step_edge_d = deb_q && !deb_prev_q && (state_q == S_STEP);
    tick_d      = run_hit || (step_edge_q && (state_q == S_STEP));
    hb_d        = hb_q ^ tick_d;
    cnt_d       = tick_d ? cnt_q + CNT_W'(1) : cnt_q;
    running_d   = (state_d == S_RUN);
  end

  always_ff @(posedge sysclk) begin
    if (reset_p) begin
      state_q     <= S_PAUSE;
      div_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      step_edge_q <= 1'b0;
      tick_q      <= 1'b0;
      hb_q        <= 1'b0;
      running_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
      state_q     <= state_d;
      div_q       <= div_d;
      sync1_q     <= step_btn;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      step_edge_q <= step_edge_d;
      tick_q      <= tick_d;
      hb_q        <= hb_d;
      running_q   <= running_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tick       = tick_q;
  assign heartbeat  = hb_q;
  assign running    = running_q;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_cpu_tick_controller.sv
// Self-checking bench for cpu_tick_controller: run-rate vector table, step/pause/reset sequences,
// and a scoreboard of expected tick cycles checked by a negedge monitor.
`timescale 1ns/1ps

module tb_cpu_tick_controller;

  localparam int DIV_LOG2  = 6;
  localparam int RATE_STEP = 1;
  localparam int DEB_LOG2  = 2;
  localparam int CNT_W     = 4;

  logic             sysclk = 1'b0;
  logic             reset_p;
  logic [1:0]       mode;
  logic [1:0]       rate_sel;
  logic             step_btn;
  logic             tick;
  logic             heartbeat;
  logic             running;
  logic [CNT_W-1:0] tick_count;

  cpu_tick_controller #(
    .DIV_LOG2 (DIV_LOG2),
    .RATE_STEP(RATE_STEP),
    .DEB_LOG2 (DEB_LOG2),
    .CNT_W    (CNT_W)
  ) dut (
    .sysclk    (sysclk),
    .reset_p   (reset_p),
    .mode      (mode),
    .rate_sel  (rate_sel),
    .step_btn  (step_btn),
    .tick      (tick),
    .heartbeat (heartbeat),
    .running   (running),
    .tick_count(tick_count)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] mode;
    logic [1:0] rate;
    int         cycles;
    int         exp_count;
    logic       exp_hb;
    logic       exp_run;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every observed tick must match the oldest expected tick cycle.
  always @(negedge sysclk) begin
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick=1 at cycle %0d expected 0", cyc);
      end else begin
        check("tick_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick_clk();
    @(posedge sysclk);
    #2;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick_clk();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_hb"}, int'(heartbeat), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_count"}, int'(tick_count), 0);
  endtask

  task automatic drain(input string tag);
    @(negedge sysclk);
    #1;
    check({tag, "_pending_ticks"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] r);
    reset_p  = 1'b1;
    mode     = m;
    rate_sel = r;
    step_btn = 1'b0;
    tick_clk();
  endtask

  initial begin
    int e0;
    int e1;
    int c;

    vecs[0] = '{mode: 2'b01, rate: 2'd0, cycles: 130, exp_count: 2,  exp_hb: 1'b0, exp_run: 1'b1};
    vecs[1] = '{mode: 2'b01, rate: 2'd2, cycles: 160, exp_count: 10, exp_hb: 1'b0, exp_run: 1'b1};
    vecs[2] = '{mode: 2'b01, rate: 2'd1, cycles: 100, exp_count: 3,  exp_hb: 1'b1, exp_run: 1'b1};
    vecs[3] = '{mode: 2'b01, rate: 2'd3, cycles: 128, exp_count: 0,  exp_hb: 1'b0, exp_run: 1'b1};
    vecs[4] = '{mode: 2'b00, rate: 2'd2, cycles: 80,  exp_count: 0,  exp_hb: 1'b0, exp_run: 1'b0};
    vecs[5] = '{mode: 2'b11, rate: 2'd3, cycles: 80,  exp_count: 0,  exp_hb: 1'b0, exp_run: 1'b0};

    // Reset held three cycles with RUN requested, then first ticks at 64 and 128.
    reset_p  = 1'b1;
    mode     = 2'b01;
    rate_sel = 2'd0;
    step_btn = 1'b0;
    repeat (3) tick_clk();
    check_zero("reset3");
    reset_p = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 64);
    exp_q.push_back(e0 + 128);
    run_until(e0 + 130);
    check("reset3_running", int'(running), 1);
    check("reset3_count", int'(tick_count), 2);
    drain("reset3");

    // Rate / mode vector table.
    for (int i = 0; i < 6; i++) begin
      int p;
      do_reset(vecs[i].mode, vecs[i].rate);
      check_zero($sformatf("vec%0d_rst", i));
      reset_p = 1'b0;
      e0 = cyc + 1;
      p  = 1 << (DIV_LOG2 - RATE_STEP * int'(vecs[i].rate));
      if (vecs[i].mode == 2'b01) begin
        for (int j = 1; p * j <= vecs[i].cycles; j++) exp_q.push_back(e0 + p * j);
      end
      run_until(e0 + vecs[i].cycles);
      check($sformatf("vec%0d_count", i), int'(tick_count), vecs[i].exp_count);
      check($sformatf("vec%0d_hb", i), int'(heartbeat), int'(vecs[i].exp_hb));
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_run));
      drain($sformatf("vec%0d", i));
    end

    // Single-step: press -> one tick 7 cycles after first sample; release and glitch -> none.
    do_reset(2'b10, 2'd0);
    reset_p = 1'b0;
    repeat (2) tick_clk();
    step_btn = 1'b1;
    c = cyc;
    exp_q.push_back(c + 8);
    repeat (12) tick_clk();
    step_btn = 1'b0;
    repeat (20) tick_clk();
    check("step_count", int'(tick_count), 1);
    check("step_hb", int'(heartbeat), 1);
    check("step_running", int'(running), 0);
    drain("step");
    step_btn = 1'b1;
    repeat (2) tick_clk();
    step_btn = 1'b0;
    repeat (20) tick_clk();
    check("glitch_count", int'(tick_count), 1);
    drain("glitch");

    // Press in PAUSE is discarded even if STEP is entered while held.
    mode     = 2'b00;
    step_btn = 1'b1;
    repeat (12) tick_clk();
    mode = 2'b10;
    repeat (5) tick_clk();
    step_btn = 1'b0;
    repeat (20) tick_clk();
    check("pause_press_count", int'(tick_count), 1);
    drain("pause_press");
    step_btn = 1'b1;
    c = cyc;
    exp_q.push_back(c + 8);
    repeat (10) tick_clk();
    step_btn = 1'b0;
    repeat (20) tick_clk();
    check("step2_count", int'(tick_count), 2);
    check("step2_hb", int'(heartbeat), 0);
    drain("step2");

    // Pause mid-period freezes count; resuming restarts a full period.
    do_reset(2'b01, 2'd0);
    reset_p = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 64);
    run_until(e0 + 100);
    check("prepause_count", int'(tick_count), 1);
    mode = 2'b00;
    repeat (50) tick_clk();
    check("pause_running", int'(running), 0);
    check("pause_count", int'(tick_count), 1);
    check("pause_hb", int'(heartbeat), 1);
    drain("pause");
    mode = 2'b01;
    e1 = cyc + 1;
    exp_q.push_back(e1 + 64);
    run_until(e1 + 70);
    check("resume_count", int'(tick_count), 2);
    check("resume_hb", int'(heartbeat), 0);
    check("resume_running", int'(running), 1);
    drain("resume");

    // One-cycle reset mid-run, then a button press in RUN gives no extra tick.
    do_reset(2'b01, 2'd0);
    reset_p = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 64);
    run_until(e0 + 70);
    check("midrun_count", int'(tick_count), 1);
    reset_p = 1'b1;
    tick_clk();
    check_zero("midrst");
    reset_p = 1'b0;
    e1 = cyc + 1;
    step_btn = 1'b1;
    repeat (12) tick_clk();
    step_btn = 1'b0;
    run_until(e1 + 40);
    check("runpress_count", int'(tick_count), 0);
    check("runpress_running", int'(running), 1);
    drain("runpress");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
